// File: rtl/dm_subword_if.sv
// Bus between the CPU pipeline and the dm_subword data memory stage.
// master = CPU side (drives the access), slave = memory side.
interface dm_subword_if;
    logic [31:0] pc;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misalign;
    logic        err_valid;
    logic [31:0] err_pc;
    logic [31:0] err_addr;

    modport master (
        output pc, mem_write, mem_op, addr, wdata,
        input  rdata, misalign, err_valid, err_pc, err_addr
    );

    modport slave (
        input  pc, mem_write, mem_op, addr, wdata,
        output rdata, misalign, err_valid, err_pc, err_addr
    );
endinterface

// File: rtl/dm_subword.sv
// Data memory stage: word/half/byte loads and stores with sticky first-error capture.
// Optional store trace printing is enabled by defining DM_SUBWORD_DISPLAY_EN.
module dm_subword #(
    parameter int ADDR_WIDTH  = 12,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    dm_subword_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int HI_W  = 30 - ADDR_WIDTH;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_HU = 3'd2;
    localparam logic [2:0] OP_B  = 3'd3;
    localparam logic [2:0] OP_BU = 3'd4;

    function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            OP_W:        return 4'b1111;
            OP_H, OP_HU: return lane[1] ? 4'b1100 : 4'b0011;
            OP_B, OP_BU: return 4'b0001 << lane;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            OP_W:        return wd;
            OP_H, OP_HU: return {2{wd[15:0]}};
            OP_B, OP_BU: return {4{wd[7:0]}};
            default:     return 32'd0;
        endcase
    endfunction

    logic [31:0]           mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_s;
    logic [1:0]            lane_s;
    logic                  in_range_s;
    logic                  align_ok_s;
    logic                  misalign_s;
    logic                  is_load_s;
    logic [31:0]           word_s;
    logic [15:0]           half_s;
    logic [7:0]            byte_s;
    logic [31:0]           rdata_s;
    logic [31:0]           wmask_s;
    logic [31:0]           merged_s;
    logic                  store_en_s;
    logic                  err_capture_s;
    logic                  err_valid_r;
    logic [31:0]           err_pc_r;
    logic [31:0]           err_addr_r;

    assign idx_s      = bus.addr[ADDR_WIDTH+1:2];
    assign lane_s     = bus.addr[1:0];
    assign in_range_s = (bus.addr[31:ADDR_WIDTH+2] == {HI_W{1'b0}});
    assign is_load_s  = (bus.mem_op <= OP_BU);
    assign word_s     = mem_r[idx_s];

    // Alignment check; reserved ops are treated as never aligned.
    always_comb begin
        align_ok_s = 1'b0;
        case (bus.mem_op)
            OP_W:        align_ok_s = (lane_s == 2'd0);
            OP_H, OP_HU: align_ok_s = ~lane_s[0];
            OP_B, OP_BU: align_ok_s = 1'b1;
            default:     align_ok_s = 1'b0;
        endcase
    end

    assign misalign_s = ~in_range_s | ~align_ok_s;

    // Combinational load extraction and extension.
    always_comb begin
        rdata_s = 32'd0;
        half_s  = lane_s[1] ? word_s[31:16] : word_s[15:0];
        case (lane_s)
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            default: byte_s = word_s[31:24];
        endcase
        if (misalign_s) begin
            rdata_s = 32'd0;
        end else begin
            case (bus.mem_op)
                OP_W:    rdata_s = word_s;
                OP_H:    rdata_s = {{16{half_s[15]}}, half_s};
                OP_HU:   rdata_s = {16'd0, half_s};
                OP_B:    rdata_s = {{24{byte_s[7]}}, byte_s};
                OP_BU:   rdata_s = {24'd0, byte_s};
                default: rdata_s = 32'd0;
            endcase
        end
    end

    assign wmask_s       = expand_mask(byte_enables(bus.mem_op, lane_s));
    assign merged_s      = (word_s & ~wmask_s) | (replicate_wdata(bus.mem_op, bus.wdata) & wmask_s);
    assign store_en_s    = bus.mem_write & ~misalign_s;
    assign err_capture_s = misalign_s & (bus.mem_write | is_load_s) & ~err_valid_r;

    generate
        if (RESET_CLEAR) begin : g_clear
            // Storage array, cleared by reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_r[i] <= 32'd0;
                    end
                end else if (store_en_s) begin
                    mem_r[idx_s] <= merged_s;
                end
            end
        end else begin : g_keep
            // Storage array, contents survive reset; a store under reset is dropped.
            always_ff @(posedge clk) begin
                if (reset_n && store_en_s) begin
                    mem_r[idx_s] <= merged_s;
                end
            end
        end
    endgenerate

    // First-error capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_valid_r <= 1'b0;
            err_pc_r    <= 32'd0;
            err_addr_r  <= 32'd0;
        end else if (err_capture_s) begin
            err_valid_r <= 1'b1;
            err_pc_r    <= bus.pc;
            err_addr_r  <= bus.addr;
        end
    end

`ifdef DM_SUBWORD_DISPLAY_EN
    // Store trace for simulation.
    always @(posedge clk) begin
        if (reset_n && store_en_s) begin
            $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged_s);
        end else if (reset_n && bus.mem_write && misalign_s) begin
            $display("DM_ERR %d@%h: suppressed store addr %h", $time, bus.pc, bus.addr);
        end
    end
`endif

    assign bus.rdata     = rdata_s;
    assign bus.misalign  = misalign_s;
    assign bus.err_valid = err_valid_r;
    assign bus.err_pc    = err_pc_r;
    assign bus.err_addr  = err_addr_r;
endmodule

// File: doc/dm_subword.md
Name: dm_subword

Overview:
- Data memory stage directly downstream of the EX-stage ALU.
- The ALU result is the byte address; the rt register value is the store data.
- Supports word, halfword and byte access: loads sign- or zero-extend; stores write through per-byte enables.
- Carries a sticky access-error capture register that the CPU top samples for debug and halt.

Parameters:
ADDR_WIDTH, 12, word-index bits; depth = 2**ADDR_WIDTH words (default 16 KiB)
RESET_CLEAR, 1, 1 = asynchronous reset zeroes the whole array; 0 = array contents unaffected by reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
pc  input  32  PC of the instruction in this stage; used by error capture and display
mem_write  input  1  store strobe for this cycle
mem_op  input  3  0=W, 1=H, 2=HU, 3=B, 4=BU; 5..7 reserved
addr  input  32  byte address (ALU result)
wdata  input  32  store data, right-aligned
rdata  output  32  load result, extended to 32 bits
misalign  output  1  combinational: current access misaligned, out of range or reserved op
err_valid  output  1  sticky: an erroneous access has occurred since reset
err_pc  output  32  pc of the first erroneous access
err_addr  output  32  addr of the first erroneous access

Behaviour:
- Word index = addr[ADDR_WIDTH+1:2]; lane = addr[1:0].
- In range iff addr[31:ADDR_WIDTH+2] == 0.
- Alignment: W needs lane==0; H/HU need lane[0]==0; B/BU always aligned.
- misalign = reserved op | out of range | alignment violation. Evaluated regardless of mem_write.
- Read path is combinational from the array (single-cycle datapath, zero latency).
  - W: whole word.
  - H/HU: halfword at lane[1] (0 = bits 15:0, 1 = bits 31:16); H sign-extends, HU zero-extends.
  - B/BU: byte at lane (lane 0 = bits 7:0); B sign-extends, BU zero-extends.
  - misalign=1 -> rdata = 0.
- Store: on rising edge with mem_write=1 and misalign=0.
  - W: all four bytes written from wdata.
  - H/HU: two bytes at lane[1] written from wdata[15:0].
  - B/BU: one byte at lane written from wdata[7:0].
  - Bytes outside the enable mask are unchanged.
- Store with misalign=1: array untouched; error capture still applies.
- Read-during-write to the same word: rdata shows the old contents in that cycle; the new value is visible the cycle after the edge.
- Error capture: on rising edge, if misalign=1 and (mem_write=1 or mem_op is a load op) and err_valid=0:
  - err_valid <= 1; err_pc <= pc; err_addr <= addr.
  - Later errors do not overwrite (first-error-wins).
  - The load-op condition applies as wired: the block has no separate read strobe, so the CPU top drives mem_op=W with addr=0 when the instruction is not a memory access.
- Reset (reset_n low, asynchronous): err_valid=0, err_pc=0, err_addr=0; if RESET_CLEAR=1, all words = 0.
  - Reset asserted coincident with a store edge: reset wins, no write.
  - Release is synchronous to the next edge only by design of the top; the block itself resumes immediately on deassertion.
- rdata and misalign are combinational; their post-reset value follows the array (0 with RESET_CLEAR=1).

Optional Feature:
- Macro DM_SUBWORD_DISPLAY_EN.
- Defined: each successful store executes $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word).
  - merged_word is the full word after byte merging.
  - Each suppressed store prints a line tagged "DM_ERR" with pc and addr.
- Undefined: no display code compiled; functionally identical otherwise.

Test Plan:
- Reset, then W load at addr 0x0000_0010 -> rdata=0x0000_0000, misalign=0, err_valid=0.
- W store 0x8899_AABB @0x20; next cycle H load @0x22 -> 0xFFFF_8899; HU load @0x22 -> 0x0000_8899; B load @0x20 -> 0xFFFF_FFBB; BU load @0x21 -> 0x0000_00AA.
- After the previous scenario, B store wdata=0x1234_5677 @0x23, then W load @0x20 -> 0x7799_AABB; H store 0xCAFE @0x20 -> W load 0x7799_CAFE.
- W store 0xDEAD_BEEF @0x25 with pc=0x3040 -> misalign=1 that cycle, word @0x24 unchanged, err_valid=1, err_pc=0x0000_3040, err_addr=0x0000_0025.
  - A second bad access H load @0x31 at pc=0x3044 -> err_pc stays 0x3040.
- W store @0x0001_0000 (out of range at default ADDR_WIDTH) -> no write, rdata=0 for that load, err capture fires.
  - mem_op=6 with mem_write=1 -> suppressed, misalign=1.
- W store 0x1 @0x40 and assert reset_n=0 mid-cycle before the edge -> error regs cleared immediately; W load @0x40 after release -> 0x0000_0000 (RESET_CLEAR=1).
  - Repeat with RESET_CLEAR=0 after a completed store of 0x5 -> rdata=0x0000_0005.
